// File: rtl/adder8_pkg.sv
// rtl/adder8_pkg.sv - shared width constant and operand type for adder8
package adder8_pkg;

  localparam int ADDER8_W = 8;

  typedef logic [ADDER8_W-1:0] adder8_word_t;

endpackage

// File: rtl/adder8_full_adder.sv
// rtl/adder8_full_adder.sv - 1-bit full adder cell of the adder8 ripple chain
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/adder8.sv
// rtl/adder8.sv - registered 8-bit ripple-carry adder with carry-out and signed overflow
// Define ADDER8_INPUT_REG_EN to register a/b before the core (2-cycle latency).
module adder8
  import adder8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  adder8_word_t a,
  input  adder8_word_t b,
  output adder8_word_t sum,
  output logic         carryout,
  output logic         overflow
);

  adder8_word_t          op_a;
  adder8_word_t          op_b;
  adder8_word_t          s_comb;
  logic [ADDER8_W:0]     c;

`ifdef ADDER8_INPUT_REG_EN
  adder8_word_t a_q;
  adder8_word_t b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = a;
  assign op_b = b;
`endif

  assign c[0] = 1'b0;

  for (genvar i = 0; i < ADDER8_W; i++) begin : g_chain
    full_adder u_fa (
      .x    (op_a[i]),
      .y    (op_b[i]),
      .cin  (c[i]),
      .s    (s_comb[i]),
      .cout (c[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= s_comb;
      carryout <= c[ADDER8_W];
      overflow <= c[ADDER8_W-1] ^ c[ADDER8_W];
    end
  end

endmodule

// File: tb/tb_adder8.sv
// tb/tb_adder8.sv - self-checking bench for adder8 against an arithmetic reference model
module tb_adder8;

`ifdef ADDER8_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       carryout;
  logic       overflow;

  int checks;
  int errors;

  logic [9:0] exp_q[$];

  adder8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {sum, carryout, overflow} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    int ux, uy, us, sx, sy, ss;
    logic [7:0] s8;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    us = ux + uy;
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    ss = sx + sy;
    s8 = 8'(us % 256);
    co = (us > 255);
    ov = (ss > 127) || (ss < -128);
    return {s8, co, ov};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    checks++;
    assert (sum === exp[9:2]) else begin
      errors++;
      $error("FAIL %s.sum observed %h expected %h", tag, sum, exp[9:2]);
    end
    checks++;
    assert (carryout === exp[1]) else begin
      errors++;
      $error("FAIL %s.carryout observed %b expected %b", tag, carryout, exp[1]);
    end
    checks++;
    assert (overflow === exp[0]) else begin
      errors++;
      $error("FAIL %s.overflow observed %b expected %b", tag, overflow, exp[0]);
    end
  endtask

  // Called at a negedge: check the oldest in-flight result, then launch x+y.
  task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic [9:0] e;
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      chk(tag, e);
    end
    a = x;
    b = y;
    exp_q.push_back(model(x, y));
  endtask

  task automatic drain(input string tag);
    logic [9:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk(tag, e);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = 8'hFF;
    b      = 8'h01;

    repeat (3) @(negedge clk);
    chk("reset_hold", 10'h000);

    // Release reset with FF+01 pending; outputs stay cleared until the next edge.
    rst_n = 1'b1;
    exp_q.push_back(model(8'hFF, 8'h01));
    #1;
    chk("pre_first_edge", 10'h000);

    @(negedge clk); step("first_capture", 8'd1,   8'd2);
    @(negedge clk); step("small_1p2",     8'd7,   8'd3);
    @(negedge clk); step("small_7p3",     8'd127, 8'd10);
    @(negedge clk); step("pos_ovf",       8'd250, 8'd236);
    @(negedge clk); step("neg_no_ovf",    8'd129, 8'd129);
    @(negedge clk); step("neg_ovf",       8'h80,  8'h80);
    @(negedge clk); step("min_min",       8'h7F,  8'h01);
    @(negedge clk); step("max_p1",        8'h00,  8'h00);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      @(negedge clk);
      step("random", ra, rb);
    end
    drain("drain");

    // Mid-stream reset: outputs must clear between clock edges.
    a = 8'h81;
    b = 8'h81;
    repeat (LAT + 1) @(negedge clk);
    chk("pre_midreset", model(8'h81, 8'h81));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_async", 10'h000);
    @(negedge clk);
    chk("midreset_held", 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder8.md
# adder8

Registered 8-bit two's-complement/unsigned adder producing sum, unsigned carry-out and signed overflow. It is the arithmetic building block of the RISC-V ALU datapath. It is built as a ripple-carry chain of 1-bit full adders with a registered result stage.

## Interface
- No parameters; operand width is fixed at 8 by the package constant `ADDER8_W`.
- clk  input  1  rising-edge clock; one clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- sum  output  8  registered a + b, modulo 256.
- carryout  output  1  registered carry out of bit 7 (unsigned overflow).
- overflow  output  1  registered signed overflow flag.
- a  input  8  operand A, interpreted as unsigned or two's complement.
- b  input  8  operand B, interpreted as unsigned or two's complement.

## Operation
- Combinational core: 8 chained full adders, carry-in to bit 0 tied to 0.
- c[i+1] = carry out of bit i. carryout = c[8].
- sum = (a + b) mod 256. The result is identical for signed and unsigned interpretation.
- overflow = c[7] XOR c[8], which is equivalent to (a[7] == b[7]) && (sum[7] != a[7]).
- Sign-mixed operands never overflow. Positive + positive giving a negative result, or negative + negative giving a positive result, sets overflow.
- carryout and overflow are independent and may both be 1, e.g. 0x81 + 0x81.
- No handshake: new operands may be applied every cycle and are fully pipelined.

## Timing
- Result registers (sum, carryout, overflow) load on every rising clk edge while rst_n = 1.
- Latency is 1 cycle: operands present before edge N appear on the outputs after edge N. With `ADDER8_INPUT_REG_EN`, latency is 2 cycles.
- Throughput is one addition per cycle.
- Reset values: sum = 8'h00, carryout = 0, overflow = 0, and any input-stage registers = 0.
- Assertion of rst_n clears all registers immediately, independent of clk. This includes reset mid-stream: any in-flight result is discarded.
- The first edge after rst_n deasserts captures the current a/b. Outputs hold their reset values until that edge.
- Combinational path a/b → result register is at most 8 full-adder carry stages.

## Configuration
- `ADDER8_INPUT_REG_EN` defined: a and b are first captured in an input register stage, and the ripple-carry core operates on the registered operands. Total latency is 2 cycles.
- `ADDER8_INPUT_REG_EN` undefined: a and b feed the core directly. Latency is 1 cycle.
- The arithmetic results and reset behaviour are identical in both builds.

## Structure
- Package `adder8_pkg` holds `ADDER8_W` = 8.
- Package `adder8_pkg` holds the typedef `adder8_word_t` (logic [ADDER8_W-1:0]).
- Sub-module `full_adder` provides inputs x, y, cin and outputs s, cout. It is instantiated 8 times via generate.
- Top `adder8` contains the generate chain, the overflow XOR, the result registers and the optional input stage.

## Test plan
- Reset: hold rst_n = 0 with a = 8'hFF, b = 8'h01 and toggle clk. Required: sum = 0, carryout = 0, overflow = 0. Then assert rst_n mid-stream: outputs clear without waiting for a clk edge.
- Small positives: a = 1, b = 2 → sum = 3, carryout = 0, overflow = 0. Also a = 7, b = 3 → sum = 10, carryout = 0, overflow = 0.
- Positive overflow: a = 127, b = 10 → sum = 137 (8'h89), carryout = 0, overflow = 1.
- Negative, no overflow: a = -6 (250), b = -20 (236) → sum = 230 (-26), carryout = 1, overflow = 0.
- Negative overflow: a = -127 (129), b = -127 (129) → sum = 2, carryout = 1, overflow = 1.
- Back-to-back: apply the four vectors above on consecutive cycles. Required: each result appears exactly 1 cycle later, or 2 cycles later with `ADDER8_INPUT_REG_EN`, with no bubbles.
